// File: rtl/router_port_tx.sv
// router_port_tx: bit-serial transmitter feeding one router input port.
// Sends a 4-bit address, a pad gap, then payload bytes LSB first.
module router_port_tx #(
    parameter int PAD_CYCLES = 5,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [3:0] pkt_addr,
    output logic       pkt_ready,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       din,
    output logic       valid_n,
    output logic       frame_n,
    output logic       busy,
    output logic       pkt_done
);

    localparam logic [3:0] PAD_W = 4'(PAD_CYCLES);
    localparam logic [3:0] GAP_W = 4'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PAD,
        DATA,
        STALL,
        GAP
    } state_t;

    state_t     state;
    logic       ready_q;
    logic [2:0] addr_sh;
    logic [6:0] shreg;
    logic       last_q;
    logic [2:0] bit_cnt;
    logic [3:0] pad_cnt;
    logic [3:0] gap_cnt;
    logic       take_pkt;

    // Header handshake; ready is masked while reset is held.
    assign pkt_ready = ready_q & ~reset;
    assign take_pkt  = pkt_valid & pkt_ready;

    // Transmit sequencer with registered serial and handshake outputs.
    always_ff @(posedge clk) begin
        pkt_done <= 1'b0;
        if (reset) begin
            state      <= IDLE;
            ready_q    <= 1'b1;
            byte_ready <= 1'b0;
            din        <= 1'b0;
            valid_n    <= 1'b1;
            frame_n    <= 1'b1;
            busy       <= 1'b0;
            addr_sh    <= '0;
            shreg      <= '0;
            last_q     <= 1'b0;
            bit_cnt    <= '0;
            pad_cnt    <= '0;
            gap_cnt    <= '0;
        end else if (take_pkt) begin
            state   <= ADDR;
            ready_q <= 1'b0;
            busy    <= 1'b1;
            din     <= pkt_addr[0];
            addr_sh <= pkt_addr[3:1];
            frame_n <= 1'b0;
            valid_n <= 1'b1;
            bit_cnt <= '0;
        end else if (byte_ready) begin
            // Fetch cycle: start the next byte or hold the frame open.
            if (byte_valid) begin
                state      <= DATA;
                shreg      <= byte_data[7:1];
                last_q     <= byte_last;
                din        <= byte_data[0];
                valid_n    <= 1'b0;
                frame_n    <= 1'b0;
                bit_cnt    <= '0;
                byte_ready <= 1'b0;
            end else begin
                state      <= STALL;
                din        <= 1'b0;
                valid_n    <= 1'b1;
                frame_n    <= 1'b0;
                byte_ready <= 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: ;
                ADDR: begin
                    if (bit_cnt == 3'd3) begin
                        state      <= PAD;
                        din        <= 1'b0;
                        pad_cnt    <= 4'd1;
                        bit_cnt    <= '0;
                        byte_ready <= (PAD_W == 4'd1);
                    end else begin
                        din     <= addr_sh[0];
                        addr_sh <= {1'b0, addr_sh[2:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                PAD: begin
                    pad_cnt    <= pad_cnt + 4'd1;
                    byte_ready <= ((pad_cnt + 4'd1) == PAD_W);
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state    <= GAP;
                        din      <= 1'b0;
                        valid_n  <= 1'b1;
                        frame_n  <= 1'b1;
                        busy     <= 1'b0;
                        pkt_done <= 1'b1;
                        gap_cnt  <= 4'd1;
                        ready_q  <= (GAP_W == 4'd1);
                    end else begin
                        din     <= shreg[0];
                        shreg   <= {1'b0, shreg[6:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd6) begin
                            frame_n    <= last_q;
                            byte_ready <= ~last_q;
                        end
                    end
                end
                STALL: ;
                GAP: begin
                    if (gap_cnt == GAP_W) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                        ready_q <= ((gap_cnt + 4'd1) == GAP_W);
                    end
                end
            endcase
        end
    end

endmodule
